// File: rtl/mux_arb2.sv
// ---------------------------------------------------------------------------
// mux_arb2 -- two-requester arbiter feeding one registered output slot.
//
// A and B each offer a word with valid/ready handshakes. A combinational
// grant, steered by a round-robin priority bit, picks one word. That word is
// loaded into a single output register whenever the register is empty or is
// being drained in the same cycle, so the block can sustain one word per cycle.
//
// Ports
//   clk      : clock; all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   a_valid  : requester A offers a_data
//   a_data   : requester A word
//   a_ready  : A's word is accepted this cycle
//   b_valid  : requester B offers b_data
//   b_data   : requester B word
//   b_ready  : B's word is accepted this cycle
//   d_valid  : output register holds a word
//   d_data   : registered selected word
//   d_ready  : consumer takes d_data this cycle
//   sel      : source of the word in d_data (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module mux_arb2 #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [DATAWIDTH-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [DATAWIDTH-1:0] b_data,
    output logic                 b_ready,
    output logic                 d_valid,
    output logic [DATAWIDTH-1:0] d_data,
    input  logic                 d_ready,
    output logic                 sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio;       // 0 = A preferred on a tie, 1 = B preferred
    logic   grant_a;
    logic   grant_b;
    logic   can_load;
    logic   load;

    // Grant, ready and next state. Ready depends only on the valids, prio and
    // the output handshake, never on the data buses. Holding rst_n low keeps
    // both readys at 0 even though the register reads empty during reset.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        state_nxt = state;
        grant_a   = a_valid & (~b_valid | ~prio);
        grant_b   = b_valid & (~a_valid |  prio);
        can_load  = rst_n & ((state == EMPTY) | d_ready);
        a_ready   = can_load & grant_a;
        b_ready   = can_load & grant_b;
        load      = a_ready | b_ready;

        if (load) begin
            // Covers the drain-and-reload case: the slot stays full.
            state_nxt = FULL;
        end else if (d_ready) begin
            state_nxt = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload, source tag and priority change only on a load. The data
    // register is reset too, so the output reads 0 rather than stale data
    // after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_data <= '0;
            sel    <= 1'b0;
            prio   <= 1'b0;
        end else if (load) begin
            d_data <= b_ready ? b_data : a_data;
            sel    <= b_ready;
            // Prefer the other requester next time: no starvation.
            prio   <= ~b_ready;
        end
    end

    assign d_valid = (state == FULL);

endmodule

// File: tb/tb_mux_arb2.sv
// ---------------------------------------------------------------------------
// tb_mux_arb2 -- self-checking bench for mux_arb2.
//
// Directed scenarios run on an 8-bit instance; a randomized run drives an
// 8-bit and a 16-bit instance side by side, each against a transaction-level
// model (accepted-word queue plus "who was served last").
// ---------------------------------------------------------------------------
module tb_mux_arb2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // 8-bit instance
    logic       a_valid, b_valid, d_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, d_valid, sel;
    logic [7:0] d_data;

    // 16-bit instance
    logic        a_valid_w, b_valid_w, d_ready_w;
    logic [15:0] a_data_w, b_data_w;
    logic        a_ready_w, b_ready_w, d_valid_w, sel_w;
    logic [15:0] d_data_w;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state for the randomized run, index 0 = 8-bit, 1 = 16-bit.
    bit          m_full [2];
    bit          last_was_a [2];   // true once A has been the most recent load
    logic [16:0] q8 [$];           // {sel, data} in acceptance order
    logic [16:0] q16 [$];

    always #5 clk = ~clk;

    mux_arb2 #(.DATAWIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .d_valid (d_valid),
        .d_data  (d_data),
        .d_ready (d_ready),
        .sel     (sel)
    );

    mux_arb2 #(.DATAWIDTH(16)) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid_w),
        .a_data  (a_data_w),
        .a_ready (a_ready_w),
        .b_valid (b_valid_w),
        .b_data  (b_data_w),
        .b_ready (b_ready_w),
        .d_valid (d_valid_w),
        .d_data  (d_data_w),
        .d_ready (d_ready_w),
        .sel     (sel_w)
    );

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; d_ready = 0; a_data = '0; b_data = '0;
        a_valid_w = 0; b_valid_w = 0; d_ready_w = 0; a_data_w = '0; b_data_w = '0;
    endtask

    // Leaves the caller at a falling edge with reset just released.
    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 0;             // asserted before any clock edge
        a_valid = 1; b_valid = 1; d_ready = 1;
        #1;
        tests_run++;
        if (d_valid !== 1'b0 || d_data !== 8'h00 || sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got d_valid=%b d_data=%h sel=%b, want 0 00 0",
                     d_valid, d_data, sel);
        end
        tests_run++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got a_ready=%b b_ready=%b, want 0 0", a_ready, b_ready);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (d_valid !== 1'b0 || d_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_held: got d_valid=%b d_data=%h, want 0 00", d_valid, d_data);
        end
        idle_inputs();
        rst_n = 1;
    endtask

    task automatic test_single_load();
        apply_reset();
        a_valid = 1; a_data = 8'h11; b_valid = 0; d_ready = 1;
        #1;
        tests_run++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        @(negedge clk);
        a_valid = 0;
        tests_run++;
        if (d_valid !== 1'b1 || d_data !== 8'h11 || sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_out: got d_valid=%b d_data=%h sel=%b, want 1 11 0",
                     d_valid, d_data, sel);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_d;
        apply_reset();
        a_valid = 1; a_data = 8'hAA; b_valid = 1; b_data = 8'hBB; d_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                tests_failed++;
                $display("FAIL alt_ready[%0d]: got a_ready=%b b_ready=%b, want %b %b",
                         i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
            end
            @(negedge clk);
            exp_d = (i % 2 == 0) ? 8'hAA : 8'hBB;
            tests_run++;
            if (d_valid !== 1'b1 || d_data !== exp_d || sel !== (i % 2 == 1)) begin
                tests_failed++;
                $display("FAIL alt_out[%0d]: got d_valid=%b d_data=%h sel=%b, want 1 %h %b",
                         i, d_valid, d_data, sel, exp_d, (i % 2 == 1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        a_valid = 1; a_data = 8'h11; d_ready = 1;
        @(negedge clk);             // holds 11 from A; B now preferred
        a_data = 8'hAA; b_valid = 1; b_data = 8'hBB; d_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_ready[%0d]: got a_ready=%b b_ready=%b, want 0 0",
                         i, a_ready, b_ready);
            end
            @(negedge clk);
            tests_run++;
            if (d_valid !== 1'b1 || d_data !== 8'h11 || sel !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got d_valid=%b d_data=%h sel=%b, want 1 11 0",
                         i, d_valid, d_data, sel);
            end
        end
        d_ready = 1;
        #1;
        tests_run++;
        if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_ready: got a_ready=%b b_ready=%b, want 0 1", a_ready, b_ready);
        end
        @(negedge clk);
        tests_run++;
        if (d_valid !== 1'b1 || d_data !== 8'hBB || sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_out: got d_valid=%b d_data=%h sel=%b, want 1 bb 1",
                     d_valid, d_data, sel);
        end
        idle_inputs();
    endtask

    task automatic test_drain();
        apply_reset();
        a_valid = 1; a_data = 8'h22; d_ready = 1;
        @(negedge clk);
        a_valid = 0;
        @(negedge clk);
        tests_run++;
        if (d_valid !== 1'b0 || d_data !== 8'h22 || sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: got d_valid=%b d_data=%h sel=%b, want 0 22 0",
                     d_valid, d_data, sel);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        b_valid = 1; b_data = 8'h33; d_ready = 0;
        @(negedge clk);
        b_valid = 0;
        tests_run++;
        if (d_valid !== 1'b1 || d_data !== 8'h33 || sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_load: got d_valid=%b d_data=%h sel=%b, want 1 33 1",
                     d_valid, d_data, sel);
        end
        #2 rst_n = 0;               // between edges
        a_valid = 1;
        #1;
        tests_run++;
        if (d_valid !== 1'b0 || d_data !== 8'h00 || sel !== 1'b0 || a_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_clear: got d_valid=%b d_data=%h sel=%b a_ready=%b, want 0 00 0 0",
                     d_valid, d_data, sel, a_ready);
        end
        @(negedge clk);
        rst_n = 1;
        a_valid = 1; a_data = 8'h44; b_valid = 1; b_data = 8'h55; d_ready = 1;
        #1;
        tests_run++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_first_grant: got a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
        end
        @(negedge clk);
        tests_run++;
        if (d_valid !== 1'b1 || d_data !== 8'h44 || sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_first_out: got d_valid=%b d_data=%h sel=%b, want 1 44 0",
                     d_valid, d_data, sel);
        end
        idle_inputs();
    endtask

    // One cycle of the transaction model for instance inst, evaluated with the
    // inputs already driven and the DUT outputs sampled before the edge.
    task automatic model_step(input int inst,
                              input logic av, input logic bv,
                              input logic [15:0] ad, input logic [15:0] bd,
                              input logic dr,
                              input logic ar, input logic br, input logic dv,
                              input logic [15:0] dd, input logic s);
        bit          room;
        int          who;   // 0 none, 1 A, 2 B
        logic [16:0] head;
        int          qsize;

        room = !m_full[inst] || dr;
        if (av && bv)  who = last_was_a[inst] ? 2 : 1;
        else if (av)   who = 1;
        else if (bv)   who = 2;
        else           who = 0;

        tests_run++;
        if (ar !== (room && who == 1) || br !== (room && who == 2)) begin
            tests_failed++;
            $display("FAIL rand%0d_ready: got a_ready=%b b_ready=%b, want %b %b",
                     inst, ar, br, (room && who == 1), (room && who == 2));
        end
        tests_run++;
        if (ar === 1'b1 && br === 1'b1) begin
            tests_failed++;
            $display("FAIL rand%0d_ready_excl: got both ready=1, want at most one", inst);
        end
        tests_run++;
        if (dv !== m_full[inst]) begin
            tests_failed++;
            $display("FAIL rand%0d_valid: got d_valid=%b, want %b", inst, dv, m_full[inst]);
        end

        if (m_full[inst]) begin
            qsize = (inst == 0) ? q8.size() : q16.size();
            tests_run++;
            if (qsize == 0) begin
                tests_failed++;
                $display("FAIL rand%0d_queue: got empty queue, want a pending word", inst);
            end else begin
                head = (inst == 0) ? q8[0] : q16[0];
                if ({s, dd} !== head) begin
                    tests_failed++;
                    $display("FAIL rand%0d_word: got sel=%b d_data=%h, want sel=%b d_data=%h",
                             inst, s, dd, head[16], head[15:0]);
                end
                if (dr) begin
                    if (inst == 0) void'(q8.pop_front());
                    else           void'(q16.pop_front());
                end
            end
        end

        if (room && who != 0) begin
            if (inst == 0) q8.push_back({who == 2, (who == 2) ? bd : ad});
            else           q16.push_back({who == 2, (who == 2) ? bd : ad});
            last_was_a[inst] = (who == 1);
        end
        m_full[inst] = (room && who != 0) || (m_full[inst] && !dr);
    endtask

    task automatic test_random();
        apply_reset();
        m_full     = '{0, 0};
        last_was_a = '{0, 0};
        q8.delete();
        q16.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            d_ready   = ($urandom_range(0, 2) != 0);
            a_data    = 8'($urandom);
            b_data    = 8'($urandom);
            a_valid_w = ($urandom_range(0, 3) != 0);
            b_valid_w = ($urandom_range(0, 3) != 0);
            d_ready_w = ($urandom_range(0, 2) != 0);
            a_data_w  = 16'($urandom);
            b_data_w  = 16'($urandom);
            #1;
            model_step(0, a_valid, b_valid, {8'h00, a_data}, {8'h00, b_data}, d_ready,
                       a_ready, b_ready, d_valid, {8'h00, d_data}, sel);
            model_step(1, a_valid_w, b_valid_w, a_data_w, b_data_w, d_ready_w,
                       a_ready_w, b_ready_w, d_valid_w, d_data_w, sel_w);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_alternate();
        test_stall();
        test_drain();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_arb2.md
MUX_ARB2 -- requirements
Module: mux_arb2

Interface
REQ-001 Parameter: DATAWIDTH, default 8, width of every data port.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 a_valid  input  1  requester A offers a word.
REQ-005 a_data  input  DATAWIDTH  requester A word.
REQ-006 a_ready  output  1  A's word accepted this cycle.
REQ-007 b_valid  input  1  requester B offers a word.
REQ-008 b_data  input  DATAWIDTH  requester B word.
REQ-009 b_ready  output  1  B's word accepted this cycle.
REQ-010 d_valid  output  1  output register holds a word.
REQ-011 d_data  output  DATAWIDTH  registered selected word.
REQ-012 d_ready  input  1  consumer takes d_data this cycle.
REQ-013 sel  output  1  source of the word in d_data (0 = A, 1 = B); registered.

Function
REQ-014 The block SHALL share one registered output between A and B, selecting the source per cycle as a 2:1 mux steered by the grant.
REQ-015 Transfer rule on every port: a word moves on a rising edge where valid and ready are both 1.
REQ-016 The block SHALL keep one state bit, full (mirrored on d_valid): EMPTY (0) or FULL (1).
REQ-017 Define can_load = !d_valid | d_ready (register empty or being drained this cycle).
REQ-018 The block SHALL keep a priority pointer prio (0 = A preferred, 1 = B preferred).
REQ-019 Grant, combinational: only A valid -> A; only B valid -> B; both valid -> requester named by prio; neither -> none.
REQ-020 a_ready = can_load & granted A; b_ready = can_load & granted B; a_ready and b_ready SHALL never both be 1.
REQ-021 Ready SHALL be independent of the non-granted requester's data and SHALL not depend on any signal other than a_valid, b_valid, prio, d_valid, d_ready.
REQ-022 On a load: d_data <= granted word, sel <= granted source, d_valid <= 1, prio <= inverse of granted source; latency from accepted input to d_valid = 1 cycle.
REQ-023 Drain without load (d_valid & d_ready, no grant): d_valid <= 0; d_data, sel, prio unchanged.
REQ-024 Simultaneous drain and load in one cycle: new word replaces old, d_valid stays 1 (full throughput, one word per cycle).
REQ-025 FULL with d_ready = 0: d_data, sel, d_valid, prio SHALL hold; a_ready = b_ready = 0.
REQ-026 prio SHALL change only on a load; a requester waiting against a continuously valid competitor SHALL be served within 2 loads (no starvation).
REQ-027 Requester dropping valid before acceptance: no side effects; no state change.
REQ-028 No X on outputs once reset has been applied, for any input sequence.

Reset
REQ-029 Rst = 0 SHALL immediately, without Clk, force d_valid = 0, d_data = 0, sel = 0, prio = 0; a_ready = b_ready = 0 while asserted.
REQ-030 Reset mid-transfer SHALL discard the held word; first grant after release with both valid goes to A.
REQ-031 Release of Rst SHALL be treated as synchronous to Clk; first load is possible on the first rising edge after release.

Verification
REQ-032 Reset, then a_valid = 1, a_data = 8'h11, b_valid = 0, d_ready = 1 -> a_ready = 1 that cycle; next cycle d_valid = 1, d_data = 8'h11, sel = 0.
REQ-033 Both valid continuously (A = 8'hAA, B = 8'hBB), d_ready = 1 -> d_data sequence AA, BB, AA, BB; sel 0,1,0,1; d_valid held 1.
REQ-034 FULL with d_data = 8'h11, d_ready = 0 for 5 cycles while both valid -> a_ready = b_ready = 0, d_data = 8'h11 held; on d_ready = 1, grant goes to prio's requester.
REQ-035 Load 8'h22, then d_ready = 1 with no valid inputs -> d_valid = 0 next cycle, d_data stays 8'h22.
REQ-036 Rst = 0 asserted between clock edges while FULL -> d_valid, d_data, sel drop to 0 before the next edge; after release both valid -> A served first.
REQ-037 Randomized valid/ready, DATAWIDTH = 8 and 16 -> every accepted word appears once, in acceptance order, with matching sel; ready never both 1.
